// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multicycle MIPS-style datapath. It sequences each
// instruction through fetch, decode and per-class execution states. It
// stretches the memory states while the memory handshake is low.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   rst           : asynchronous active-high reset, returns the FSM to FETCH
//   opcode[5:0]   : instruction bits [31:26], looked at only in DECODE
//   zero          : ALU zero flag; the branch decision itself is formed in the
//                   datapath as pc_write_cond & zero
//   mem_ready     : memory access completes in the cycle it is high
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a : datapath strobes / selects
//   alu_src_b[1:0]: 00 reg B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   alu_op[1:0]   : 00 add, 01 subtract, 10 decode funct
//   pc_source[1:0]: 00 ALU result, 01 ALU out register, 10 jump target
//   instr_done    : pulse in the last state of every instruction
//   illegal_op    : pulse in DECODE for an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_LW  = 3'd1,
        CLS_SW  = 3'd2,
        CLS_BEQ = 3'd3,
        CLS_J   = 3'd4,
        CLS_ILL = 3'd5
    } cls_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;

    // The branch decision uses zero in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cls_q   <= CLS_R;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            FETCH: begin
                // PC+4 is computed every cycle; PC and IR are committed only
                // when the instruction word actually arrives.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Speculative branch target PC + (imm << 2).
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW: begin
                        cls_d   = CLS_LW;
                        state_d = MEM_ADDR;
                    end
                    OP_SW: begin
                        cls_d   = CLS_SW;
                        state_d = MEM_ADDR;
                    end
                    OP_RTYP: begin
                        cls_d   = CLS_R;
                        state_d = EXECUTE;
                    end
                    OP_BEQ: begin
                        cls_d   = CLS_BEQ;
                        state_d = BRANCH;
                    end
                    OP_J: begin
                        cls_d   = CLS_J;
                        state_d = JUMP;
                    end
                    default: begin
                        cls_d      = CLS_ILL;
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // The latched class decides here because opcode may have moved on.
                state_d   = (cls_q == CLS_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // The state register already sits in FETCH while rst is high. Only
        // the side-effecting strobes need masking, so the datapath cannot
        // commit anything during reset.
        if (rst) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            pc_write_cond = 1'b0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; forces state FETCH immediately, independent of clk.
REQ-003 opcode  input  6  instruction bits [31:26] from instruction register; sampled only in DECODE.
REQ-004 zero  input  1  ALU zero flag; sampled only in BRANCH.
REQ-005 mem_ready  input  1  memory handshake; current access completes in the cycle it is 1.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
REQ-007 alu_src_b  output  2  ALU B select: 00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-008 alu_op  output  2  feeds ALU control: 00=add, 01=subtract, 10=decode funct; 11 is never driven.
REQ-009 pc_source  output  2  00=ALU result, 01=ALU out register, 10=jump target.
REQ-010 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-011 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-012 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP; 4-bit state register, all other encodings go to FETCH next cycle.
REQ-013 Outputs are combinational from state plus mem_ready/zero as stated; each unlisted output is 0 in every state.
REQ-014 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stays in FETCH while mem_ready=0, else DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEM_ADDR, 000000 -> EXECUTE, 000100 -> BRANCH, 000010 -> JUMP, other -> FETCH with illegal_op=1.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ if latched opcode is 100011, else MEM_WRITE.
REQ-017 Opcode class is latched in DECODE; opcode changes after DECODE shall not alter the sequence.
REQ-018 MEM_READ: mem_read=1, i_or_d=1; waits while mem_ready=0, then MEM_WB.
REQ-019 MEM_WRITE: mem_write=1, i_or_d=1; waits while mem_ready=0; on mem_ready=1 instr_done=1 and next FETCH.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
REQ-021 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
REQ-022 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; effective PC write is pc_write_cond AND zero, formed in datapath; instr_done=1; next FETCH.
REQ-024 JUMP: pc_write=1, pc_source=10, instr_done=1; next FETCH.
REQ-025 Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
REQ-026 Each cycle mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds exactly one cycle; outputs held constant during wait.
REQ-027 mem_read and mem_write are never both 1; reg_write and pc_write are never both 1.

Reset
REQ-028 rst=1 sets state FETCH asynchronously; latched opcode class cleared to R-type.
REQ-029 While rst=1, pc_write, ir_write, mem_write, reg_write, pc_write_cond, instr_done, illegal_op are forced 0; remaining outputs take FETCH values.
REQ-030 rst asserted mid-instruction (any state, including memory wait) aborts it; no instr_done pulse; first cycle after release is FETCH.

Verification
REQ-031 lw (100011), mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB; reg_write=1,mem_to_reg=1 in cycle 5; instr_done once.
REQ-032 sw with mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write=1 held 4 cycles, instr_done on 4th, total 7 cycles.
REQ-033 beq with zero=1 then zero=0 -> pc_write_cond=1, alu_op=01, pc_source=01 in BRANCH both times; 3 cycles each.
REQ-034 R-type -> alu_op=10 in EXECUTE, reg_dst=1 in R_WB; opcode toggled to 000100 after DECODE does not divert.
REQ-035 opcode 111111 -> illegal_op=1 in DECODE, FETCH next, no instr_done, no write strobes.
REQ-036 rst pulsed asynchronously during MEM_READ wait -> write strobes 0 immediately, FETCH after release, mem_read/mem_write never both 1 throughout.
